// File: rtl/audio_rx_deframer_pkg.sv
// Shared types and constants for the stereo audio receive deframer.
// Optional error counter build: AUDIO_RX_ERROR_COUNT_EN.
package audio_rx_deframer_pkg;

    localparam int AUDIO_WIDTH_DEF  = 16;
    localparam int BUFFER_DEPTH_DEF = 4;

    localparam logic ID_LEFT  = 1'b0;
    localparam logic ID_RIGHT = 1'b1;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/audio_rx_deframer_if.sv
// Beat input stream and FIFO read side of the audio receive deframer.
// master = stream source / reader, slave = deframer.
interface audio_rx_deframer_if
    import audio_rx_deframer_pkg::*;
#(
    parameter int AUDIO_WIDTH  = AUDIO_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
) ();

    logic [31:0]              data_in;
    logic                     id_in;
    logic                     valid_in;
    logic                     ready_in;
    logic [AUDIO_WIDTH*2-1:0] data_out;
    logic                     rd_en;
    logic                     empty_out;
    logic [BUFFER_DEPTH:0]    level_out;

    modport master (
        output data_in,
        output id_in,
        output valid_in,
        input  ready_in,
        input  data_out,
        output rd_en,
        input  empty_out,
        input  level_out
    );

    modport slave (
        input  data_in,
        input  id_in,
        input  valid_in,
        output ready_in,
        output data_out,
        input  rd_en,
        output empty_out,
        output level_out
    );

endinterface

// File: rtl/audio_rx_deframer_fifo.sv
// Single-clock show-ahead FIFO holding packed stereo words.
// Head word is presented combinationally from the read pointer.
module audio_rx_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    assign w_full = r_level[DEPTH_LOG2];
    assign w_pop  = rd_en & (r_level != '0);
    // A pop in the same cycle frees the slot a write into a full FIFO uses
    assign w_push = wr_en & (~w_full | w_pop);

    assign dout  = r_mem[r_rptr];
    assign empty = (r_level == '0);
    assign level = r_level;

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Wrapping read/write pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy counter; push and pop together leave it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/audio_rx_deframer.sv
// Pairs left/right audio beats into stereo words and buffers them.
// Optional framing error counter: define AUDIO_RX_ERROR_COUNT_EN.
module audio_rx_deframer
    import audio_rx_deframer_pkg::*;
#(
    parameter int AUDIO_WIDTH  = AUDIO_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    audio_rx_deframer_if.slave  bus,
    output logic [15:0]         err_count
);

    localparam int W2 = AUDIO_WIDTH * 2;
    localparam logic [BUFFER_DEPTH+1:0] LP_DEPTH =
        (BUFFER_DEPTH+2)'(1 << BUFFER_DEPTH);

    rx_state_e               r_state;
    rx_state_e               w_state_nxt;
    logic [AUDIO_WIDTH-1:0]  r_left;
    logic [AUDIO_WIDTH-1:0]  w_left_nxt;
    logic [W2-1:0]           r_pend_word;
    logic [W2-1:0]           w_pend_word_nxt;
    logic                    r_pend;
    logic                    w_pend_nxt;
    logic                    r_run;
    logic                    w_hs;
    logic                    w_err;
    logic [AUDIO_WIDTH-1:0]  w_sample;
    logic [BUFFER_DEPTH:0]   w_level;
    logic [BUFFER_DEPTH+1:0] w_occupied;
    logic                    w_unused;

    assign w_sample   = bus.data_in[31 -: AUDIO_WIDTH];
    assign w_occupied = {1'b0, w_level} + {{(BUFFER_DEPTH+1){1'b0}}, r_pend};
    // Conservative: any beat is refused once FIFO plus pending word is full
    assign bus.ready_in = r_run & (w_occupied < LP_DEPTH);
    assign w_hs         = bus.valid_in & bus.ready_in;
    assign w_unused     = ^{bus.data_in, w_err};

    // Holds ready low while in reset and until the first cycle after it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Deframer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_L;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, left capture, pair completion and framing error detect
    always_comb begin
        w_state_nxt     = r_state;
        w_left_nxt      = r_left;
        w_pend_nxt      = 1'b0;
        w_pend_word_nxt = r_pend_word;
        w_err           = 1'b0;
        if (w_hs) begin
            case (r_state)
                WAIT_L: begin
                    if (bus.id_in == ID_LEFT) begin
                        w_left_nxt  = w_sample;
                        w_state_nxt = WAIT_R;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus.id_in == ID_RIGHT) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_word_nxt = {r_left, w_sample};
                        w_state_nxt     = WAIT_L;
                    end else begin
                        w_err      = 1'b1;
                        w_left_nxt = w_sample;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_L;
                end
            endcase
        end
    end

    // Held left sample and the one-stage pending write register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left      <= '0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
        end else begin
            r_left      <= w_left_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_word <= w_pend_word_nxt;
        end
    end

`ifdef AUDIO_RX_ERROR_COUNT_EN
    logic [15:0] r_err_count;

    // Saturating count of framing errors, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err) begin
            r_err_count <= sat_inc16(r_err_count);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'd0;
`endif

    audio_rx_fifo #(
        .WIDTH      (W2),
        .DEPTH_LOG2 (BUFFER_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (r_pend),
        .din   (r_pend_word),
        .rd_en (bus.rd_en),
        .dout  (bus.data_out),
        .empty (bus.empty_out),
        .level (w_level)
    );

    assign bus.level_out = w_level;

endmodule
